// File: rtl/grf_wb_sched_pkg.sv
// Shared widths and the write-back request record used by the GRF write scheduler.
package grf_pkg;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam int NREG   = 32;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] pc;
  } wb_req_t;
endpackage

// File: rtl/grf_wb_sched_if.sv
// Bundle of the pipeline, MDU, D-stage read and GRF write-port signals of the scheduler.
interface grf_wb_sched_if;
  import grf_pkg::*;

  logic              pipe_we;
  logic [REG_AW-1:0] pipe_addr;
  logic [DATA_W-1:0] pipe_data;
  logic [DATA_W-1:0] pipe_pc;

  logic              mdu_issue;
  logic [REG_AW-1:0] mdu_issue_addr;
  logic              mdu_done_valid;
  logic              mdu_done_ready;
  logic [REG_AW-1:0] mdu_done_addr;
  logic [DATA_W-1:0] mdu_done_data;
  logic [DATA_W-1:0] mdu_done_pc;

  logic [REG_AW-1:0] rd_addr1;
  logic [REG_AW-1:0] rd_addr2;
  logic              stall;

  logic              grf_we;
  logic [REG_AW-1:0] grf_waddr;
  logic [DATA_W-1:0] grf_wdata;
  logic [DATA_W-1:0] grf_wpc;
  logic [NREG-1:0]   busy_mask;

  // Producer side: pipeline, MDU and decode stage.
  modport master (
    output pipe_we, pipe_addr, pipe_data, pipe_pc,
    output mdu_issue, mdu_issue_addr,
    output mdu_done_valid, mdu_done_addr, mdu_done_data, mdu_done_pc,
    output rd_addr1, rd_addr2,
    input  mdu_done_ready, stall,
    input  grf_we, grf_waddr, grf_wdata, grf_wpc, busy_mask
  );

  // Scheduler side.
  modport slave (
    input  pipe_we, pipe_addr, pipe_data, pipe_pc,
    input  mdu_issue, mdu_issue_addr,
    input  mdu_done_valid, mdu_done_addr, mdu_done_data, mdu_done_pc,
    input  rd_addr1, rd_addr2,
    output mdu_done_ready, stall,
    output grf_we, grf_waddr, grf_wdata, grf_wpc, busy_mask
  );
endinterface

// File: rtl/grf_wb_sched_fifo.sv
// Small synchronous FIFO of write-back requests; head is visible combinationally.
module wb_fifo
  import grf_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          push,
  input  logic          pop,
  input  wb_req_t       push_req,
  output wb_req_t       head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  wb_req_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem[rd_ptr_q];

  // Next-state for pointers and occupancy; requests beyond capacity are ignored.
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok) count_d = count_q + CW'(1);
    if (pop_ok && !push_ok) count_d = count_q - CW'(1);
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_req;
  end
endmodule

// File: rtl/grf_wb_sched.sv
// GRF write-port scheduler: pipeline write-back first, queued MDU results fill idle
// cycles, and a busy scoreboard stalls decode on registers with results outstanding.
module grf_wb_sched
  import grf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic          clk,
  input logic          Reset,
  grf_wb_sched_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  wb_req_t           push_req, head;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CW-1:0]     fifo_count;
  logic              pipe_sel;

  logic              we_q, we_d;
  logic [REG_AW-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] wpc_q, wpc_d;
  logic [NREG-1:0]   busy_q, busy_d;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .Reset    (Reset),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .push_req (push_req),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Ready comes from registered occupancy, so a full queue refuses even when popping.
  assign bus.mdu_done_ready = (fifo_count < CW'(DEPTH));

  // Port arbitration, output register next-state and scoreboard update.
  always_comb begin
    push_req  = '{addr: bus.mdu_done_addr, data: bus.mdu_done_data, pc: bus.mdu_done_pc};
    pipe_sel  = bus.pipe_we && (bus.pipe_addr != '0);
    fifo_pop  = !pipe_sel && !fifo_empty;
    fifo_push = bus.mdu_done_valid && !fifo_full;
    we_d      = 1'b0;
    waddr_d   = '0;
    wdata_d   = '0;
    wpc_d     = '0;
    busy_d    = busy_q;
    if (pipe_sel) begin
      we_d    = 1'b1;
      waddr_d = bus.pipe_addr;
      wdata_d = bus.pipe_data;
      wpc_d   = bus.pipe_pc;
    end else if (fifo_pop) begin
      // Results for $0 are drained without a write.
      we_d    = (head.addr != '0);
      waddr_d = head.addr;
      wdata_d = head.data;
      wpc_d   = head.pc;
      if (head.addr != '0) busy_d[head.addr] = 1'b0;
    end
    // A new issue to the same register outranks the clear of its older result.
    if (bus.mdu_issue && (bus.mdu_issue_addr != '0)) busy_d[bus.mdu_issue_addr] = 1'b1;
  end

  // Decode hazard check; busy[0] is never set, the explicit guards keep $0 obvious.
  always_comb begin
    bus.stall = ((bus.rd_addr1 != '0) && busy_q[bus.rd_addr1]) ||
                ((bus.rd_addr2 != '0) && busy_q[bus.rd_addr2]) ||
                (bus.mdu_issue && (bus.mdu_issue_addr != '0) && busy_q[bus.mdu_issue_addr]);
  end

  // Registered write port and scoreboard.
  always_ff @(posedge clk) begin
    if (Reset) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      wpc_q   <= '0;
      busy_q  <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wpc_q   <= wpc_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.grf_we    = we_q;
  assign bus.grf_waddr = waddr_q;
  assign bus.grf_wdata = wdata_q;
  assign bus.grf_wpc   = wpc_q;
  assign bus.busy_mask = busy_q;
endmodule

// File: tb/tb_grf_wb_sched.sv
// Directed bench for the GRF write scheduler with hand-computed expectations.
module tb_grf_wb_sched;
  logic clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  grf_wb_sched_if bus();

  grf_wb_sched #(.DEPTH(2)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pipe_we        = 1'b0;
    bus.pipe_addr      = '0;
    bus.pipe_data      = '0;
    bus.pipe_pc        = '0;
    bus.mdu_issue      = 1'b0;
    bus.mdu_issue_addr = '0;
    bus.mdu_done_valid = 1'b0;
    bus.mdu_done_addr  = '0;
    bus.mdu_done_data  = '0;
    bus.mdu_done_pc    = '0;
    bus.rd_addr1       = '0;
    bus.rd_addr2       = '0;
  endtask

  task automatic offer(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    bus.mdu_done_valid = 1'b1;
    bus.mdu_done_addr  = a;
    bus.mdu_done_data  = d;
    bus.mdu_done_pc    = pc;
  endtask

  task automatic pipe(input logic we, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    bus.pipe_we   = we;
    bus.pipe_addr = a;
    bus.pipe_data = d;
    bus.pipe_pc   = pc;
  endtask

  initial begin
    idle();
    // Reset held two cycles with traffic present.
    Reset = 1'b1;
    offer(5'd5, 32'h5555, 32'h50);
    bus.mdu_issue = 1'b1; bus.mdu_issue_addr = 5'd7;
    pipe(1'b1, 5'd2, 32'h22, 32'h20);
    tick(); tick();
    chk("rst_we",    bus.grf_we, 0);
    chk("rst_waddr", bus.grf_waddr, 0);
    chk("rst_wdata", bus.grf_wdata, 0);
    chk("rst_wpc",   bus.grf_wpc, 0);
    chk("rst_ready", bus.mdu_done_ready, 1);
    chk("rst_busy",  bus.busy_mask, 0);
    Reset = 1'b0;
    idle();
    tick();
    chk("post_rst_we",   bus.grf_we, 0);
    chk("post_rst_busy", bus.busy_mask, 0);

    // Pipeline-only writes, then a dropped $0 write.
    pipe(1'b1, 5'd5, 32'h1234, 32'h400);
    tick();
    chk("pipe_we",    bus.grf_we, 1);
    chk("pipe_waddr", bus.grf_waddr, 5);
    chk("pipe_wdata", bus.grf_wdata, 32'h1234);
    chk("pipe_wpc",   bus.grf_wpc, 32'h400);
    bus.pipe_addr = 5'd0;
    tick();
    chk("pipe_r0_we", bus.grf_we, 0);
    idle();

    // Arbitration: MDU result queued behind three pipeline writes.
    bus.mdu_issue = 1'b1; bus.mdu_issue_addr = 5'd8;
    tick();
    bus.mdu_issue = 1'b0;
    chk("arb_busy_set", bus.busy_mask, 32'h100);
    bus.rd_addr1 = 5'd8;
    chk("arb_stall_pre", bus.stall, 1);
    offer(5'd8, 32'hAA, 32'h800);
    tick();
    bus.mdu_done_valid = 1'b0;
    chk("arb_no_bypass", bus.grf_we, 0);
    for (int i = 0; i < 3; i++) begin
      pipe(1'b1, 5'd3, 32'h30 + i, 32'h300);
      tick();
      chk("arb_pipe_we",    bus.grf_we, 1);
      chk("arb_pipe_waddr", bus.grf_waddr, 3);
      chk("arb_pipe_wdata", bus.grf_wdata, 32'h30 + i);
      chk("arb_stall_q",    bus.stall, 1);
    end
    pipe(1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    chk("arb_mdu_we",    bus.grf_we, 1);
    chk("arb_mdu_waddr", bus.grf_waddr, 8);
    chk("arb_mdu_wdata", bus.grf_wdata, 32'hAA);
    chk("arb_mdu_wpc",   bus.grf_wpc, 32'h800);
    chk("arb_busy_clr",  bus.busy_mask, 0);
    chk("arb_stall_clr", bus.stall, 0);
    bus.rd_addr1 = 5'd0;
    tick();
    chk("arb_idle_we", bus.grf_we, 0);

    // Full queue: third offer refused while count is 2 even with a pop.
    pipe(1'b1, 5'd3, 32'h3, 32'h300);
    offer(5'd10, 32'h11, 32'hA0);
    tick();
    chk("full_e1_waddr", bus.grf_waddr, 3);
    offer(5'd11, 32'h22, 32'hB0);
    tick();
    chk("full_ready0", bus.mdu_done_ready, 0);
    offer(5'd12, 32'h33, 32'hC0);
    pipe(1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    chk("full_pop1_waddr", bus.grf_waddr, 10);
    chk("full_pop1_wdata", bus.grf_wdata, 32'h11);
    chk("full_ready1",     bus.mdu_done_ready, 1);
    tick();
    bus.mdu_done_valid = 1'b0;
    chk("full_pop2_waddr", bus.grf_waddr, 11);
    chk("full_pop2_wdata", bus.grf_wdata, 32'h22);
    tick();
    chk("full_pop3_we",    bus.grf_we, 1);
    chk("full_pop3_waddr", bus.grf_waddr, 12);
    chk("full_pop3_wpc",   bus.grf_wpc, 32'hC0);
    tick();
    chk("full_drained_we", bus.grf_we, 0);

    // Scoreboard: stall until popped; same-cycle issue beats the clear.
    bus.mdu_issue = 1'b1; bus.mdu_issue_addr = 5'd9;
    tick();
    bus.mdu_issue = 1'b0;
    bus.rd_addr1 = 5'd9;
    chk("sb_stall_issued", bus.stall, 1);
    offer(5'd9, 32'h99, 32'h900);
    tick();
    bus.mdu_done_valid = 1'b0;
    chk("sb_stall_queued", bus.stall, 1);
    bus.mdu_issue = 1'b1; bus.mdu_issue_addr = 5'd9;
    tick();
    bus.mdu_issue = 1'b0;
    chk("sb_pop_waddr",  bus.grf_waddr, 9);
    chk("sb_pop_wdata",  bus.grf_wdata, 32'h99);
    chk("sb_set_wins",   bus.busy_mask, 32'h200);
    chk("sb_stall_kept", bus.stall, 1);
    offer(5'd9, 32'h9A, 32'h904);
    tick();
    bus.mdu_done_valid = 1'b0;
    tick();
    chk("sb_pop2_wdata", bus.grf_wdata, 32'h9A);
    chk("sb_busy_clr",   bus.busy_mask, 0);
    chk("sb_stall_clr",  bus.stall, 0);
    bus.rd_addr1 = 5'd0;

    // Results for $0 are accepted and drained without a write; $0 never becomes busy.
    offer(5'd0, 32'hDEAD, 32'hD0);
    bus.mdu_issue = 1'b1; bus.mdu_issue_addr = 5'd0;
    tick();
    idle();
    chk("r0_busy", bus.busy_mask, 0);
    tick();
    chk("r0_pop_we", bus.grf_we, 0);
    chk("r0_ready",  bus.mdu_done_ready, 1);

    // Reset mid-operation with two queued results.
    bus.mdu_issue = 1'b1; bus.mdu_issue_addr = 5'd4;
    tick();
    bus.mdu_issue_addr = 5'd6;
    tick();
    bus.mdu_issue = 1'b0;
    pipe(1'b1, 5'd3, 32'h3, 32'h300);
    offer(5'd4, 32'h44, 32'h440);
    tick();
    offer(5'd6, 32'h66, 32'h660);
    tick();
    idle();
    chk("mid_busy",  bus.busy_mask, 32'h50);
    chk("mid_ready", bus.mdu_done_ready, 0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("mid_rst_we",    bus.grf_we, 0);
    chk("mid_rst_busy",  bus.busy_mask, 0);
    chk("mid_rst_ready", bus.mdu_done_ready, 1);
    bus.rd_addr1 = 5'd4;
    bus.rd_addr2 = 5'd6;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_after_we",    bus.grf_we, 0);
      chk("mid_after_stall", bus.stall, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
